// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator for the RV32I core.
// Issues word addresses to a 1-cycle registered instruction memory, captures
// the returned words into a 2-entry buffer and presents them to decode with a
// valid/ready handshake. Redirects flush all buffered and in-flight fetches;
// a misaligned redirect target parks the unit in a fault state until the next
// aligned redirect or reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_fault
);

    // The buffer logic below is written for exactly two entries.
    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);
    localparam logic [2:0] OCC_MAX  = 3'(BUF_DEPTH);

    logic [31:0] r_fetchPc;
    logic [31:0] r_inflightPc;
    logic        r_inflight;
    logic        r_fault;

    logic [1:0]  r_count;
    logic [31:0] r_bufInstr [2];
    logic [31:0] r_bufPc    [2];

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occupancy;

    // A handshake completes whenever the head is valid and decode is ready,
    // even in the same cycle as a redirect.
    assign w_pop  = (r_count != 2'd0) && if_ready;
    // The memory answers one cycle after an issue; imem_rdata is meaningless
    // otherwise (including its reset value of zero).
    assign w_push = r_inflight;

    // Entries that will occupy the buffer once everything already requested
    // lands, net of the entry leaving this cycle.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Issuing is blocked during a redirect so the old stream cannot leak a
    // request past the flush; the reset gate keeps the bus idle while held.
    assign w_issue = !reset && !r_fault && !redirect_valid && (w_occupancy < OCC_MAX);

    assign imem_req       = w_issue;
    assign imem_addr      = r_fetchPc;
    assign misalign_fault = r_fault;
    assign if_valid       = (r_count != 2'd0);
    assign if_instr       = r_bufInstr[0];
    assign if_pc          = r_bufPc[0];

    // Fetch PC, in-flight tracking and fault flag; a redirect overrides any
    // issue and records whether the new target is word aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetchPc    <= RESET_PC;
            r_inflightPc <= 32'h0000_0000;
            r_inflight   <= 1'b0;
            r_fault      <= 1'b0;
        end else if (redirect_valid) begin
            r_fetchPc  <= redirect_pc;
            r_inflight <= 1'b0;
            r_fault    <= (redirect_pc[1:0] != 2'b00);
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflightPc <= r_fetchPc;
                r_fetchPc    <= r_fetchPc + 32'd4;
            end
        end
    end

    // Two-entry FIFO kept head-aligned in slot 0 so the decode outputs come
    // straight from registers; a redirect discards both slots and the
    // response landing this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= 2'd0;
            r_bufInstr[0] <= 32'h0000_0000;
            r_bufInstr[1] <= 32'h0000_0000;
            r_bufPc[0]    <= 32'h0000_0000;
            r_bufPc[1]    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_bufInstr[0] <= imem_rdata;
                        r_bufPc[0]    <= r_inflightPc;
                    end else begin
                        r_bufInstr[0] <= r_bufInstr[1];
                        r_bufPc[0]    <= r_bufPc[1];
                        r_bufInstr[1] <= imem_rdata;
                        r_bufPc[1]    <= r_inflightPc;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_bufInstr[0] <= imem_rdata;
                        r_bufPc[0]    <= r_inflightPc;
                    end else begin
                        r_bufInstr[1] <= imem_rdata;
                        r_bufPc[1]    <= r_inflightPc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_bufInstr[0] <= r_bufInstr[1];
                    r_bufPc[0]    <= r_bufPc[1];
                    r_count       <= r_count - 2'd1;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // The issue rule must never let a response arrive into a full buffer.
    assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == BUF_FULL) && !w_pop))
        else $error("instr_fetch_unit: push into full buffer");

endmodule
